// File: rtl/strip_ws281x_multi.sv
`default_nettype none
// ============================================================================
// Module      : strip_ws281x_multi
// Description : Multi-channel WS281x strip driver. All channels share one bit
//               phase counter, so every strip output stays bit-aligned. Each
//               strip receives one pixel per handshake, through a one-entry
//               holding register. A frame sends LED_COUNT pixels per strip and
//               then a latch (reset) low period. A frame is aborted if the
//               next pixel has not arrived by the end of the current pixel.
// Config      : STRIP_WS281X_AUTO_RESTART_EN - when defined, a new frame
//               starts on leaving the latch period without waiting for start_i.
// Ports       : clk_i          - sole clock, rising edge
//               rst_n_i        - asynchronous active-low reset
//               start_i        - single-cycle frame request (honoured in IDLE)
//               pixel_data_i   - one pixel per channel, channel 0 in the LSBs,
//                                each packed {R,G,B[,W]} with R in the MSBs
//               pixel_valid_i  - pixel_data_i holds the next LED
//               pixel_ready_o  - block accepts pixel_data_i this cycle
//               led_data_o     - registered serial data, one bit per strip
//               busy_o         - frame in progress, including the latch period
//               frame_done_o   - one-cycle pulse at frame completion
//               underrun_o     - one-cycle pulse when a frame is aborted
// Revision    : 1.0 - initial release
// ============================================================================
module strip_ws281x_multi #(
    parameter int CHANNELS       = 4,
    parameter int LED_COUNT      = 300,
    parameter int BITS_PER_PIXEL = 24,
    parameter int GRB_ORDER      = 1,
    parameter int CYCLES_0_HIGH  = 21,
    parameter int CYCLES_1_HIGH  = 42,
    parameter int CYCLES_BIT     = 63,
    parameter int CYCLES_RESET   = 2600
) (
    input  logic                               clk_i,
    input  logic                               rst_n_i,
    input  logic                               start_i,
    input  logic [CHANNELS*BITS_PER_PIXEL-1:0] pixel_data_i,
    input  logic                               pixel_valid_i,
    output logic                               pixel_ready_o,
    output logic [CHANNELS-1:0]                led_data_o,
    output logic                               busy_o,
    output logic                               frame_done_o,
    output logic                               underrun_o
);

    localparam int BPP   = BITS_PER_PIXEL;
    localparam int CNT_W = $clog2(LED_COUNT) + 1;
    localparam int PH_W  = $clog2(CYCLES_BIT) + 1;
    localparam int BIT_W = $clog2(BPP) + 1;
    localparam int LAT_W = $clog2(CYCLES_RESET) + 1;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LED_COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CYCLES_BIT - 1);
    localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
    localparam logic [PH_W-1:0]  HI0      = PH_W'(CYCLES_0_HIGH);
    localparam logic [PH_W-1:0]  HI1      = PH_W'(CYCLES_1_HIGH);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BPP - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(CYCLES_RESET - 1);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_FIRST = 2'd1,
        S_BIT        = 2'd2,
        S_LATCH      = 2'd3
    } state_t;

    state_t                         state;
    state_t                         next_state;
    logic                           hold_full;
    logic [CHANNELS*BPP-1:0]        hold_data;
    logic [CNT_W-1:0]               accept_cnt;   // pixels still to be accepted
    logic [CNT_W-1:0]               send_cnt;     // pixels still to be loaded
    logic [BIT_W-1:0]               bit_cnt;
    logic [PH_W-1:0]                phase;
    logic [LAT_W-1:0]               latch_cnt;
    logic [CHANNELS-1:0][BPP-1:0]   shift_q;      // MSB is the bit on the wire
    logic [CHANNELS-1:0][BPP-1:0]   load_word;
    logic [CHANNELS-1:0]            hi_bits;

    logic xfer;
    logic bit_end;
    logic pixel_end;
    logic latch_end;
    logic load_shift;
    logic start_frame;
    logic abort;
    logic frame_end;

    assign busy_o        = (state != S_IDLE);
    assign pixel_ready_o = busy_o && !hold_full && (accept_cnt != '0);
    assign xfer          = pixel_valid_i && pixel_ready_o;
    assign bit_end       = (state == S_BIT) && (phase == PH_LAST);
    assign pixel_end     = bit_end && (bit_cnt == BIT_LAST);
    assign latch_end     = (state == S_LATCH) && (latch_cnt == LAT_LAST);

    // Per-channel wire ordering and high-time decode for the current bit.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [BPP-1:0] px;
        assign px = hold_data[c*BPP +: BPP];
        if (GRB_ORDER != 0) begin : g_grb
            assign load_word[c] = {px[BPP-9:BPP-16], px[BPP-1:BPP-8], px[BPP-17:0]};
        end else begin : g_rgb
            assign load_word[c] = px;
        end
        assign hi_bits[c] = (phase < (shift_q[c][BPP-1] ? HI1 : HI0));
    end

    always_comb begin
        next_state  = state;
        load_shift  = 1'b0;
        start_frame = 1'b0;
        abort       = 1'b0;
        frame_end   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    next_state  = S_WAIT_FIRST;
                    start_frame = 1'b1;
                end
            end
            S_WAIT_FIRST: begin
                if (hold_full) begin
                    next_state = S_BIT;
                    load_shift = 1'b1;
                end
            end
            S_BIT: begin
                if (pixel_end) begin
                    if (send_cnt == '0) begin
                        next_state = S_LATCH;
                    end else if (hold_full) begin
                        load_shift = 1'b1;       // seamless pixel-to-pixel reload
                    end else begin
                        next_state = S_LATCH;
                        abort      = 1'b1;
                    end
                end
            end
            S_LATCH: begin
                if (latch_end) begin
                    frame_end = 1'b1;
`ifdef STRIP_WS281X_AUTO_RESTART_EN
                    next_state  = S_WAIT_FIRST;
                    start_frame = 1'b1;
`else
                    next_state  = S_IDLE;
`endif
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= S_IDLE;
            hold_full    <= 1'b0;
            hold_data    <= '0;
            accept_cnt   <= '0;
            send_cnt     <= '0;
            bit_cnt      <= '0;
            phase        <= '0;
            latch_cnt    <= '0;
            shift_q      <= '0;
            led_data_o   <= '0;
            frame_done_o <= 1'b0;
            underrun_o   <= 1'b0;
        end else begin
            state        <= next_state;
            frame_done_o <= frame_end;
            underrun_o   <= abort;
            led_data_o   <= (state == S_BIT) ? hi_bits : '0;

            // An aborted frame stops accepting so no stale pixel survives.
            if (start_frame)
                accept_cnt <= CNT_INIT;
            else if (abort)
                accept_cnt <= '0;
            else if (xfer)
                accept_cnt <= accept_cnt - CNT_ONE;

            if (xfer) begin
                hold_full <= 1'b1;
                hold_data <= pixel_data_i;
            end else if (load_shift) begin
                hold_full <= 1'b0;
            end

            if (start_frame)
                send_cnt <= CNT_INIT;
            else if (load_shift)
                send_cnt <= send_cnt - CNT_ONE;

            if (load_shift) begin
                shift_q <= load_word;
                bit_cnt <= '0;
                phase   <= '0;
            end else if (state == S_BIT) begin
                if (bit_end) begin
                    phase   <= '0;
                    bit_cnt <= bit_cnt + BIT_ONE;
                    for (int c = 0; c < CHANNELS; c++)
                        shift_q[c] <= {shift_q[c][BPP-2:0], 1'b0};
                end else begin
                    phase <= phase + PH_ONE;
                end
            end else begin
                phase   <= '0;
                bit_cnt <= '0;
            end

            if ((state == S_LATCH) && !latch_end)
                latch_cnt <= latch_cnt + LAT_ONE;
            else
                latch_cnt <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_strip_ws281x_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_strip_ws281x_multi
// Description : Self-checking bench for strip_ws281x_multi with two LEDs per
//               strip on two channels. Two instances share the stimulus, one
//               sending GRB order and one RGB order. Expected waveforms come
//               from a cycle-indexed model of the serial protocol.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_strip_ws281x_multi;

    localparam int CH   = 2;
    localparam int NLED = 2;
    localparam int BPP  = 24;
    localparam int T0H  = 21;
    localparam int T1H  = 42;
    localparam int TBIT = 63;
    localparam int TRST = 2600;
`ifdef STRIP_WS281X_AUTO_RESTART_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                valid = 1'b0;
    logic [CH*BPP-1:0]   pdata = '0;
    logic                rdy_g, busy_g, done_g, und_g;
    logic                rdy_r, busy_r, done_r, und_r;
    logic [CH-1:0]       led_g, led_r;

    always #5 clk = ~clk;

    strip_ws281x_multi #(.CHANNELS(CH), .LED_COUNT(NLED), .BITS_PER_PIXEL(BPP), .GRB_ORDER(1))
    dut_grb (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .pixel_data_i(pdata),
        .pixel_valid_i(valid), .pixel_ready_o(rdy_g), .led_data_o(led_g),
        .busy_o(busy_g), .frame_done_o(done_g), .underrun_o(und_g)
    );

    strip_ws281x_multi #(.CHANNELS(CH), .LED_COUNT(NLED), .BITS_PER_PIXEL(BPP), .GRB_ORDER(0))
    dut_rgb (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .pixel_data_i(pdata),
        .pixel_valid_i(valid), .pixel_ready_o(rdy_r), .led_data_o(led_r),
        .busy_o(busy_r), .frame_done_o(done_r), .underrun_o(und_r)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [23:0] p0c0;
        logic [23:0] p0c1;
        logic [23:0] p1c0;
        logic [23:0] p1c1;
        int          a0;       // cycle offering pixel 0
        int          a1;       // cycle offering pixel 1
        bit          give1;    // pixel 1 offered at all
        int          start_k;  // stray start_i cycle, -1 for none
        int          exp_und;  // expected underrun pulses
        int          exp_done; // expected frame_done pulses
    } vec_t;

    task automatic check(input string what, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", what, act, req);
        end
    endtask

    // Level expected on a strip at cycle k of a frame whose first bit begins at t0.
    function automatic bit exp_led_bit(input logic [23:0] px0, input logic [23:0] px1,
                                       input bit grb, input int k, input int t0, input int tend);
        int          off, idx, ph;
        logic [23:0] px, w;
        if (k < t0 || k >= tend) return 1'b0;
        off = k - t0;
        idx = off / TBIT;
        ph  = off % TBIT;
        px  = (idx < BPP) ? px0 : px1;
        w   = grb ? {px[15:8], px[23:16], px[7:0]} : px;
        return ph < (w[BPP-1-(idx % BPP)] ? T1H : T0H);
    endfunction

    // k counts falling edges after the edge that captured start_i (or, when
    // chained, after the edge that left the previous latch period).
    task automatic run_frame(input string tag, input vec_t v, input bit chained);
        int t0, tend, tdone, kend;
        int m_led, m_busy, m_done, m_und, m_rdy, f_led, f_ctl, n_done, n_und;
        logic [CH-1:0] eg, er;
        bit eb, ed, eu, erdy;
        t0    = v.a0 + 3;
        tend  = t0 + TBIT * (v.give1 ? 2 * BPP : BPP);
        tdone = tend - 1 + TRST;
        kend  = AUTO ? tdone - 1 : tdone + 20;
        m_led = 0; m_busy = 0; m_done = 0; m_und = 0; m_rdy = 0;
        f_led = -1; f_ctl = -1; n_done = 0; n_und = 0;
        if (!chained) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int k = 0; k <= kend; k++) begin
            eg[0] = exp_led_bit(v.p0c0, v.p1c0, 1'b1, k, t0, tend);
            eg[1] = exp_led_bit(v.p0c1, v.p1c1, 1'b1, k, t0, tend);
            er[0] = exp_led_bit(v.p0c0, v.p1c0, 1'b0, k, t0, tend);
            er[1] = exp_led_bit(v.p0c1, v.p1c1, 1'b0, k, t0, tend);
            eb    = (k < tdone) || AUTO;
            ed    = (k == tdone) || (chained && k == 0);
            eu    = !v.give1 && (k == tend - 1);
            if (k <= v.a0)          erdy = 1'b1;
            else if (k == v.a0 + 1) erdy = 1'b0;
            else if (v.give1)       erdy = (k <= v.a1);
            else                    erdy = (k < tend - 1);
            if (led_g !== eg || led_r !== er) begin
                if (m_led == 0) f_led = k;
                m_led++;
            end
            if (busy_g !== eb || busy_r !== eb) begin m_busy++; if (f_ctl < 0) f_ctl = k; end
            if (done_g !== ed || done_r !== ed) begin m_done++; if (f_ctl < 0) f_ctl = k; end
            if (und_g !== eu || und_r !== eu)   begin m_und++;  if (f_ctl < 0) f_ctl = k; end
            if (rdy_g !== erdy || rdy_r !== erdy) begin m_rdy++; if (f_ctl < 0) f_ctl = k; end
            if (done_g === 1'b1) n_done++;
            if (und_g === 1'b1) n_und++;
            valid = (k == v.a0) || (v.give1 && k == v.a1);
            if (k == v.a0)                pdata = {v.p0c1, v.p0c0};
            else if (v.give1 && k == v.a1) pdata = {v.p1c1, v.p1c0};
            else                          pdata = {16'($urandom), 32'($urandom)};
            start = (k == v.start_k);
            @(negedge clk);
        end
        valid = 1'b0;
        start = 1'b0;
        check($sformatf("%s led bad cycles (first k=%0d)", tag, f_led), m_led, 0);
        check($sformatf("%s busy bad cycles (first ctl k=%0d)", tag, f_ctl), m_busy, 0);
        check($sformatf("%s frame_done bad cycles", tag), m_done, 0);
        check($sformatf("%s underrun bad cycles", tag), m_und, 0);
        check($sformatf("%s pixel_ready bad cycles", tag), m_rdy, 0);
        check($sformatf("%s frame_done pulses", tag), n_done, v.exp_done);
        check($sformatf("%s underrun pulses", tag), n_und, v.exp_und);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        vec_t v;
        int   cnt;
        // p0c0,    p0c1,     p1c0,     p1c1,     a0, a1,   give, start_k, und, done
        tbl[0] = '{24'hFF0000, 24'h0000FF, 24'hFF0000, 24'h0000FF, 0, 2, 1'b1, -1, 0, 1};
        tbl[1] = '{24'hFF0000, 24'h0000FF, 24'h000000, 24'h000000, 3, 0, 1'b0, -1, 1, 1};
        tbl[2] = '{24'h123456, 24'hA5C3F0, 24'h00FF00, 24'h800001, 17, 17 + 1512, 1'b1, 100, 0, 1};
        tbl[3] = '{24'hFFFFFF, 24'h000000, 24'h55AA55, 24'hAAAAAA, 1, 500, 1'b1, 4000, 0, 1};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset led_g", int'(led_g), 0);
        check("reset led_r", int'(led_r), 0);
        check("reset busy", int'(busy_g), 0);
        check("reset ready", int'(rdy_g), 0);
        check("reset done/underrun", int'({done_g, und_g}), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle without start busy", int'(busy_g), 0);

`ifdef STRIP_WS281X_AUTO_RESTART_EN
        v = tbl[0];
        v.exp_done = 0;
        run_frame("auto frame1", v, 1'b0);
        v.exp_done = 1;
        run_frame("auto frame2", v, 1'b1);
        check("auto frame3 done pulse", int'(done_g), 1);
        check("auto frame3 busy", int'(busy_g), 1);
`else
        for (int i = 0; i < 4; i++)
            run_frame($sformatf("vec%0d", i), tbl[i], 1'b0);

        // Asynchronous reset in the middle of a high bit time.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        valid = 1'b1;
        pdata = {24'hFF0000, 24'hFF0000};
        @(negedge clk);
        valid = 1'b0;
        repeat (7) @(negedge clk);
        check("pre-reset led high", int'(led_g), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset led_g", int'(led_g), 0);
        check("async reset led_r", int'(led_r), 0);
        check("async reset busy", int'(busy_g), 0);
        check("async reset ready", int'(rdy_g), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_g || und_g || busy_g || (led_g != 0)) cnt++;
        end
        check("post-reset quiet cycles with activity", cnt, 0);

        // Randomized frames, some with the second pixel withheld.
        for (int i = 0; i < 3; i++) begin
            v.p0c0    = 24'($urandom);
            v.p0c1    = 24'($urandom);
            v.p1c0    = 24'($urandom);
            v.p1c1    = 24'($urandom);
            v.a0      = int'($urandom_range(0, 10));
            v.give1   = ($urandom_range(0, 3) != 0);
            v.a1      = v.a0 + 2 + int'($urandom_range(0, 1510));
            v.start_k = int'($urandom_range(0, 3000));
            v.exp_und = v.give1 ? 0 : 1;
            v.exp_done = 1;
            run_frame($sformatf("rand%0d", i), v, 1'b0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
